uart_receiver: RTL
==================

# uart_receiver

UART serial receiver: the stage that consumes the TX line produced by the transmitter path, recovering bytes from an asynchronous 8N1 serial stream. It shares the 16x oversampling `tick_in` from the existing baud rate generator, synchronises the line, validates the start bit, samples each bit at its centre and reports the byte with a one-cycle strobe plus error flags. It sits between the board RX pin and whatever consumes received bytes (loopback checker, LEDs, FIFO).

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `OVERSAMPLE`, 16: `tick_in` pulses per bit period; must be even and ≥ 4.
- `system_clk`  in  1: system clock (100 MHz).
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `tick_in`  in  1: one-cycle oversampling strobe from the baud generator.
- `rx_data`  in  1: asynchronous serial line, idle high.
- `data_out`  out  DATA_BITS: last received byte.
- `rx_done`  out  1: one-cycle pulse when a frame completes.
- `frame_err`  out  1: stop bit sampled low in the last frame.
- `parity_err`  out  1: parity mismatch in the last frame. Constant 0 without parity.

## Operation
- `rx_data` passes through a 2-FF synchroniser, reset value 1. All decisions use the synchronised bit `rx_s`.
- States: IDLE, START, DATA, PARITY (macro only), STOP. `tick_cnt` is `$clog2(OVERSAMPLE)` bits; `bit_cnt` is `$clog2(DATA_BITS)` bits.
- IDLE: `rx_s == 0` → START, `tick_cnt` cleared. Ticks are ignored while in IDLE.
- START: counts `tick_in`. On tick `OVERSAMPLE/2` (mid start bit):
  - if `rx_s == 0` → DATA, with `tick_cnt` and `bit_cnt` cleared;
  - else → IDLE as a glitch, with no outputs changed.
- DATA: on every `OVERSAMPLE`-th tick, shift `rx_s` into the MSB of the shift register (right shift, so the LSB arrives first). After bit `DATA_BITS-1` → PARITY or STOP.
- STOP: on the `OVERSAMPLE`-th tick, sample the stop bit, then in the same cycle:
  - `data_out` ← shift register;
  - `frame_err` ← `~rx_s`;
  - `parity_err` updated;
  - `rx_done` = 1;
  - return to IDLE.
- A completed frame always updates `data_out` and pulses `rx_done`, even with errors. The error flags describe that frame and hold until the next `rx_done`.
- Returning to IDLE at mid stop bit allows a back-to-back start edge with a single stop bit.
- Line held low after a frame (break): re-enters START and DATA, receives 0x00 with `frame_err = 1`. No special break handling.

## Timing
- Reset values: `data_out` = 0, `rx_done` = 0, `frame_err` = 0, `parity_err` = 0, state IDLE, counters 0, synchroniser FFs = 1.
- `rst` mid-frame aborts immediately. No `rx_done` is produced for the aborted frame.
- Line-to-detection latency is 2 `system_clk` cycles (synchroniser).
- `rx_done` asserts in the cycle after the `tick_in` that samples the stop bit. It is high for exactly 1 cycle and never on consecutive cycles.
- `data_out` and the error flags change only in the `rx_done` cycle.
- A `tick_in` coinciding with `rst` is ignored.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state is inserted after DATA.
  - It samples one bit after `OVERSAMPLE` ticks.
  - `parity_err` ← (XOR of data bits ^ parity bit) != 0, i.e. even parity.
  - Frame length becomes 11 bits.
- Undefined: no PARITY state, and `parity_err` is tied to 0.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `rx_state_t`;
  - defaults `UART_DATA_BITS = 8` and `UART_OVERSAMPLE = 16`.
- The transmitter reuses the same package constants.
- Sub-module `sync_2ff`: a two-flop synchroniser with a parameterised reset value of 1.

## Test plan
All scenarios drive the line from a bench model, with `tick_in` every 4 cycles.
- Valid frame 0xA5, stop = 1 → `data_out` = 0xA5, `rx_done` high for 1 cycle, `frame_err` = 0.
- Frame 0x3C with stop = 0 → `rx_done` pulses, `data_out` = 0x3C, `frame_err` = 1. The next valid frame 0x12 clears `frame_err`.
- Start glitch, line low for 3 ticks then high → no `rx_done`, and the FSM is back in IDLE. A following 0x55 frame is received correctly.
- Back-to-back 0x00 then 0xFF with a single stop bit between them → exactly two `rx_done` pulses, with correct values in order.
- `rst` asserted for 1 cycle during data bit 3 → all outputs 0, no `rx_done`. A subsequent frame 0x81 is received correctly.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → `parity_err` = 0. Same byte with parity bit 0 → `parity_err` = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame constants.
// The transmitter uses the same constants so both ends agree on the frame format.
`timescale 1ns/1ps
package uart_pkg;
   localparam int UART_DATA_BITS  = 8;
   localparam int UART_OVERSAMPLE = 16;

   // PARITY is only visited when UART_RX_PARITY_EN is defined
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;
endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: serial line and baud tick in, received byte and status out.
// master = the receiver, slave = whoever drives the line and consumes bytes.
`timescale 1ns/1ps
interface uart_receiver_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS
);
   logic                 tick_in;
   logic                 rx_data;
   logic [DATA_BITS-1:0] data_out;
   logic                 rx_done;
   logic                 frame_err;
   logic                 parity_err;

   modport master (
      input  tick_in, rx_data,
      output data_out, rx_done, frame_err, parity_err
   );

   modport slave (
      output tick_in, rx_data,
      input  data_out, rx_done, frame_err, parity_err
   );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a configurable
// reset value so an idle-high line does not look like a start bit after reset.
`timescale 1ns/1ps
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic srst,
   input  logic d,
   output logic q
);
   logic meta_reg;
   logic sync_reg;

   // shift the async bit through two flops
   always_ff @(posedge clk) begin
      if (srst) begin
         meta_reg <= RESET_VAL;
         sync_reg <= RESET_VAL;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver driven by a 16x oversampling tick. Validates the start bit
// at its centre, samples each data bit at its centre, and reports every
// completed frame with a one-cycle rx_done plus sticky-per-frame error flags.
// Optional feature: define UART_RX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
`timescale 1ns/1ps
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic            system_clk,
   input  logic            rst,
   uart_receiver_if.master rx_if
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 tick;
   rx_state_t            state_reg, state_next;
   logic [TW-1:0]        tick_cnt_reg, tick_cnt_next;
   logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic [DATA_BITS-1:0] data_reg, data_next;
   logic                 rx_done_reg, rx_done_next;
   logic                 frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
   logic                 parity_bit_reg, parity_bit_next;
   logic                 parity_err_reg, parity_err_next;
`endif

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk  (system_clk),
      .srst (rst),
      .d    (rx_if.rx_data),
      .q    (rx_s)
   );

   assign tick = rx_if.tick_in;

   // state and datapath registers; reset aborts any frame in flight
   always_ff @(posedge system_clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         tick_cnt_reg   <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         data_reg       <= '0;
         rx_done_reg    <= 1'b0;
         frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bit_reg <= 1'b0;
         parity_err_reg <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         tick_cnt_reg   <= tick_cnt_next;
         bit_cnt_reg    <= bit_cnt_next;
         shift_reg      <= shift_next;
         data_reg       <= data_next;
         rx_done_reg    <= rx_done_next;
         frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
         parity_bit_reg <= parity_bit_next;
         parity_err_reg <= parity_err_next;
`endif
      end
   end

   // next-state and datapath updates; outputs only move when a frame completes
   always_comb begin
      state_next      = state_reg;
      tick_cnt_next   = tick_cnt_reg;
      bit_cnt_next    = bit_cnt_reg;
      shift_next      = shift_reg;
      data_next       = data_reg;
      rx_done_next    = 1'b0;
      frame_err_next  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
      parity_bit_next = parity_bit_reg;
      parity_err_next = parity_err_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (!rx_s) begin
               state_next    = START;
               tick_cnt_next = '0;
            end
         end
         START: begin
            if (tick) begin
               if (tick_cnt_reg == HALF_LAST) begin
                  tick_cnt_next = '0;
                  if (!rx_s) begin
                     state_next   = DATA;
                     bit_cnt_next = '0;
                  end else begin
                     // line went high again before mid start bit: noise
                     state_next = IDLE;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tick_cnt_reg == FULL_LAST) begin
                  tick_cnt_next = '0;
                  shift_next    = {rx_s, shift_reg[DATA_BITS-1:1]};
                  if (bit_cnt_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_next = PARITY;
`else
                     state_next = STOP;
`endif
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 1'b1;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (tick_cnt_reg == FULL_LAST) begin
                  tick_cnt_next   = '0;
                  parity_bit_next = rx_s;
                  state_next      = STOP;
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (tick_cnt_reg == FULL_LAST) begin
                  // leave at mid stop bit so a back-to-back start edge is caught
                  tick_cnt_next   = '0;
                  data_next       = shift_reg;
                  frame_err_next  = ~rx_s;
                  rx_done_next    = 1'b1;
                  state_next      = IDLE;
`ifdef UART_RX_PARITY_EN
                  parity_err_next = (^shift_reg) ^ parity_bit_reg;
`endif
               end else begin
                  tick_cnt_next = tick_cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign rx_if.data_out  = data_reg;
   assign rx_if.rx_done   = rx_done_reg;
   assign rx_if.frame_err = frame_err_reg;
`ifdef UART_RX_PARITY_EN
   assign rx_if.parity_err = parity_err_reg;
`else
   assign rx_if.parity_err = 1'b0;
`endif
endmodule
